// File: rtl/config_writer.sv
// Configuration image writer: shadow load, atomic commit, optional readback.
// Readback is compiled in when CONFIG_WRITER_READBACK_EN is defined.
module config_writer #(
  parameter int CW     = 16,
  parameter int NWORDS = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_data,
  output logic                 in_ready,
  output logic [CW*NWORDS-1:0] cfg_out,
  output logic                 cfg_valid,
  output logic                 busy,
  output logic                 done
`ifdef CONFIG_WRITER_READBACK_EN
  ,
  input  logic                 rb_start,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_data
`endif
);

  localparam int CNTW =
    (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNTW-1:0] LAST =
    CNTW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
`ifdef CONFIG_WRITER_READBACK_EN
    ,
    S_READBACK
`endif
  } state_t;

  state_t                 state;
  logic [CNTW-1:0]        cnt;
  logic [CW*NWORDS-1:0]   shadow;
  logic [CW*NWORDS-1:0]   img;
  logic                   hs;
  int                     idx;

  assign in_ready = (state == S_LOAD) && !abort;
  assign hs       = in_valid && in_ready;
  assign idx      = int'(cnt);

  // Image as it will look once the word on the bus lands.
  always_comb begin
    img = shadow;
    img[idx*CW +: CW] = in_data;
  end

`ifdef CONFIG_WRITER_READBACK_EN
  logic [CNTW-1:0] rb_cnt;
  int              rb_idx;

  assign rb_idx    = int'(rb_cnt);
  assign out_valid = (state == S_READBACK);
  assign out_data  = cfg_out[rb_idx*CW +: CW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shadow    <= '0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CONFIG_WRITER_READBACK_EN
      rb_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state <= S_LOAD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
`ifdef CONFIG_WRITER_READBACK_EN
          else if (rb_start && !abort) begin
            state  <= S_READBACK;
            rb_cnt <= '0;
            busy   <= 1'b1;
          end
`endif
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (hs) begin
            shadow[idx*CW +: CW] <= in_data;
            if (cnt == LAST) begin
              cfg_out   <= img;
              cfg_valid <= 1'b1;
              done      <= 1'b1;
              state     <= S_COMMIT;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
`ifdef CONFIG_WRITER_READBACK_EN
        S_READBACK: begin
          if (abort) begin
            state  <= S_IDLE;
            rb_cnt <= '0;
            busy   <= 1'b0;
          end else if (out_ready) begin
            if (rb_cnt == LAST) begin
              state  <= S_IDLE;
              rb_cnt <= '0;
              busy   <= 1'b0;
            end else begin
              rb_cnt <= rb_cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_writer.sv
// Directed self-checking bench for config_writer (CW=16, NWORDS=7).
module tb_config_writer;

  localparam int CW = 16;
  localparam int NW = 7;
  localparam int IW = CW * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic          in_ready;
  logic [IW-1:0] cfg_out;
  logic          cfg_valid;
  logic          busy;
  logic          done;
`ifdef CONFIG_WRITER_READBACK_EN
  logic          rb_start;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
`endif

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  logic [IW-1:0] img_seq;
  logic [IW-1:0] img_a;
  logic [IW-1:0] img_b;

  config_writer #(.CW(CW), .NWORDS(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cfg_out  (cfg_out),
    .cfg_valid(cfg_valid),
    .busy     (busy),
    .done     (done)
`ifdef CONFIG_WRITER_READBACK_EN
    ,
    .rb_start (rb_start),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (done === 1'b1) done_seen++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input logic [IW-1:0] img);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      in_valid = 1'b1;
      in_data  = img[k*CW +: CW];
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (cfg_out !== '0 || cfg_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_cfg: cfg_out=%h valid=%b want 0/0",
               cfg_out, cfg_valid);
    end
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: ready=%b busy=%b done=%b want 000",
               in_ready, busy, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b ready=%b want 0/0",
               busy, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_enter: busy=%b ready=%b want 1/1",
               busy, in_ready);
    end
    for (int k = 0; k < NW; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k + 1);
      tick();
      if (k < NW - 1) begin
        total++;
        if (cfg_out !== '0 || cfg_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_partial%0d: cfg_out=%h want 0",
                   k, cfg_out);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (cfg_out !== img_seq || cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_commit: cfg_out=%h valid=%b want %h/1",
               cfg_out, cfg_valid, img_seq);
    end
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: done=%b ready=%b want 1/0",
               done, in_ready);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after: done=%b busy=%b want 0/0",
               done, busy);
    end
    total++;
    if (done_seen - d0 != 1) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d want 1", done_seen - d0);
    end
  endtask

  task automatic test_abort;
    int d0;
    load_image(img_a);
    total++;
    if (cfg_out !== img_a) begin
      bad++;
      $display("FAIL abort_a: cfg_out=%h want %h", cfg_out, img_a);
    end
    // start and abort together: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_vs_start: busy=%b want 0", busy);
    end
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = img_b[k*CW +: CW];
      tick();
    end
    in_data = 16'hFFFF;
    abort   = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready: in_ready=%b want 0", in_ready);
    end
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || cfg_out !== img_a || cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_keep: busy=%b cfg_out=%h want 0/%h",
               busy, cfg_out, img_a);
    end
    tick();
    total++;
    if (done_seen != d0) begin
      bad++;
      $display("FAIL abort_nodone: pulses=%0d want 0",
               done_seen - d0);
    end
    load_image(img_b);
    total++;
    if (cfg_out !== img_b || done_seen - d0 != 1) begin
      bad++;
      $display("FAIL abort_b: cfg_out=%h pulses=%0d want %h/1",
               cfg_out, done_seen - d0, img_b);
    end
  endtask

  task automatic test_gaps;
    logic [IW-1:0] exp_img;
    int            n;
    int            d0;
    int            cyc;
    d0  = done_seen;
    n   = 0;
    cyc = 0;
    for (int k = 0; k < NW; k++)
      exp_img[k*CW +: CW] = 16'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n < NW && cyc < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = in_valid ? exp_img[n*CW +: CW] : 16'($urandom);
      if (in_valid && in_ready) n++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (n != NW) begin
      bad++;
      $display("FAIL gaps_timeout: accepted=%0d want %0d", n, NW);
    end
    tick();
    tick();
    total++;
    if (cfg_out !== exp_img || done_seen - d0 != 1) begin
      bad++;
      $display("FAIL gaps_img: cfg_out=%h pulses=%0d want %h/1",
               cfg_out, done_seen - d0, exp_img);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (cfg_out !== '0 || cfg_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_cfg: cfg_out=%h valid=%b want 0/0",
               cfg_out, cfg_valid);
    end
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ctl: ready=%b busy=%b want 0/0",
               in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_image(img_seq);
    total++;
    if (cfg_out !== img_seq || cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_resume: cfg_out=%h want %h",
               cfg_out, img_seq);
    end
  endtask

`ifdef CONFIG_WRITER_READBACK_EN
  task automatic test_readback;
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    rb_start = 1'b1;
    tick();
    rb_start = 1'b0;
    while (n < NW && cyc < 100) begin
      out_ready = cyc[0];
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== 16'(n + 1)) begin
          bad++;
          $display("FAIL rb_word%0d: out_data=%h want %h",
                   n, out_data, 16'(n + 1));
        end
        n++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (n != NW || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rb_end: words=%0d busy=%b want %0d/0",
               n, busy, NW);
    end
    total++;
    if (cfg_out !== img_seq) begin
      bad++;
      $display("FAIL rb_cfg: cfg_out=%h want %h", cfg_out, img_seq);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef CONFIG_WRITER_READBACK_EN
    rb_start  = 1'b0;
    out_ready = 1'b0;
`endif
    for (int k = 0; k < NW; k++) begin
      img_seq[k*CW +: CW] = 16'(k + 1);
      img_a[k*CW +: CW]   = 16'hA000 + 16'(k);
      img_b[k*CW +: CW]   = 16'hB100 + 16'(k * 3);
    end
    test_reset();
    test_back_to_back();
    test_abort();
    test_gaps();
    test_reset_mid();
`ifdef CONFIG_WRITER_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
